// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared types and helpers for the registered 1-to-N stream
//               demultiplexer (FSM state encoding, parameter check, one-hot).
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    // Widest select the helpers below can represent
    localparam int c_max_sel_w = 8;
    localparam int c_max_ch    = 2 ** c_max_sel_w;

    // Packet-level state, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    // True when SEL_W can address every channel and fits the helper range
    function automatic bit sel_w_ok(input int sel_w, input int num_ch);
        return (num_ch >= 2) && (sel_w <= c_max_sel_w) &&
               (sel_w >= $clog2(num_ch));
    endfunction

    // One-hot decode of ch; bits at or above num_ch are always zero
    function automatic logic [c_max_ch-1:0] onehot(input logic [c_max_sel_w-1:0] ch,
                                                   input int num_ch);
        logic [c_max_ch-1:0] v;
        v = '0;
        for (int i = 0; i < c_max_ch; i++) begin
            v[i] = (i < num_ch) && (ch == c_max_sel_w'(i));
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_hold_reg
// Description : Single-entry valid/ready holding register carrying one beat
//               (data, last flag, destination channel). Push and pop may
//               happen in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_hold_reg #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic [SEL_W-1:0]  i_ch,
    input  logic              i_sink_ready,
    output logic              o_ready,
    output logic              o_hv,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic [SEL_W-1:0]  o_ch
);

    logic              r_hv;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [SEL_W-1:0]  r_ch;

    // Room for a new beat when empty or when the held beat leaves this cycle
    assign o_ready = !r_hv || i_sink_ready;

    // Load on push, otherwise clear valid on pop; contents frozen while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hv   <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
            r_ch   <= '0;
        end else if (i_push) begin
            r_hv   <= 1'b1;
            r_data <= i_data;
            r_last <= i_last;
            r_ch   <= i_ch;
        end else if (r_hv && i_sink_ready) begin
            r_hv   <= 1'b0;
        end
    end

    assign o_hv   = r_hv;
    assign o_data = r_data;
    assign o_last = r_last;
    assign o_ch   = r_ch;

endmodule
`default_nettype wire

// File: rtl/demux_stream_1n.sv
`default_nettype none
// ============================================================================
// Module      : demux_stream_1n
// Description : Registered 1-to-NUM_CH valid/ready stream demultiplexer.
//               Destination is latched from the first beat of each packet;
//               packets addressed beyond NUM_CH are swallowed and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_stream_1n
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              busy
);

    generate
        if (!sel_w_ok(SEL_W, NUM_CH)) begin : g_bad_params
            $error("demux_stream_1n: SEL_W=%0d cannot address NUM_CH=%0d", SEL_W, NUM_CH);
        end
    endgenerate

    localparam logic [SEL_W:0]   c_num_ch  = (SEL_W+1)'(NUM_CH);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_pkt_ch;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic                w_sel_ok;
    logic                w_accept;
    logic                w_in_ready;
    logic                w_push;
    logic                w_drop_first;
    logic                w_busy;
    logic [SEL_W-1:0]    w_push_ch;

    logic                w_hold_ready;
    logic                w_hv;
    logic [SEL_W-1:0]    w_hold_ch;
    logic                w_sink_ready;
    // Full-width decode; only the low NUM_CH bits are meaningful
    logic [c_max_ch-1:0] w_ch_oh_wide_unused_hi;
    logic [NUM_CH-1:0]   w_ch_oh;

    assign w_sel_ok = {1'b0, in_sel} < c_num_ch;

    // Drop state swallows beats without waiting on any sink
    assign w_in_ready = !rst && ((r_state == DROP) || w_hold_ready);
    assign w_accept   = in_valid && w_in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: only accepted beats move the FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !in_last) begin
                    w_state_nxt = w_sel_ok ? FWD : DROP;
                end
            end
            FWD, DROP: begin
                if (w_accept && in_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: what an accepted beat does and where it goes
    always_comb begin
        w_push       = 1'b0;
        w_drop_first = 1'b0;
        w_push_ch    = r_pkt_ch;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_push       = w_accept && w_sel_ok;
                w_drop_first = w_accept && !w_sel_ok;
                w_push_ch    = in_sel;
                w_busy       = 1'b0;
            end
            FWD: begin
                w_push       = w_accept;
            end
            DROP: begin
                w_push       = 1'b0;
            end
            default: begin
                w_busy       = 1'b0;
            end
        endcase
    end

    // Latch the packet's channel on its first loaded beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_ch <= '0;
        end else if ((r_state == IDLE) && w_push) begin
            r_pkt_ch <= in_sel;
        end
    end

    // Count discarded packets once, on their first beat, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_first && (r_drop_cnt != c_cnt_max)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    demux_hold_reg #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_hold (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_data       (in_data),
        .i_last       (in_last),
        .i_ch         (w_push_ch),
        .i_sink_ready (w_sink_ready),
        .o_ready      (w_hold_ready),
        .o_hv         (w_hv),
        .o_data       (out_data),
        .o_last       (out_last),
        .o_ch         (w_hold_ch)
    );

    // The held beat's own channel selects both its valid bit and its ready
    assign w_ch_oh_wide_unused_hi = onehot(c_max_sel_w'(w_hold_ch), NUM_CH);
    assign w_ch_oh                = w_ch_oh_wide_unused_hi[NUM_CH-1:0];
    assign w_sink_ready           = |(w_ch_oh & out_ready);

    assign out_valid = w_ch_oh & {NUM_CH{w_hv}};
    assign in_ready  = w_in_ready;
    assign drop_cnt  = r_drop_cnt;
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_1n.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_stream_1n
// Description : Directed self-checking bench for demux_stream_1n (8-channel
//               and 6-channel builds sharing clock and reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_stream_1n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // 8-channel build
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic [7:0] drop_cnt;
    logic       busy;

    // 6-channel build
    logic [7:0] d6_in_data;
    logic [2:0] d6_in_sel;
    logic       d6_in_valid;
    logic       d6_in_last;
    logic       d6_in_ready;
    logic [7:0] d6_out_data;
    logic       d6_out_last;
    logic [5:0] d6_out_valid;
    logic [5:0] d6_out_ready;
    logic [7:0] d6_drop_cnt;
    logic       d6_busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demux_stream_1n #(.DATA_W(8), .NUM_CH(8), .SEL_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .drop_cnt(drop_cnt), .busy(busy)
    );

    demux_stream_1n #(.DATA_W(8), .NUM_CH(6), .SEL_W(3), .CNT_W(8)) dut6 (
        .clk(clk), .rst(rst),
        .in_data(d6_in_data), .in_sel(d6_in_sel), .in_valid(d6_in_valid),
        .in_last(d6_in_last), .in_ready(d6_in_ready),
        .out_data(d6_out_data), .out_last(d6_out_last), .out_valid(d6_out_valid),
        .out_ready(d6_out_ready), .drop_cnt(d6_drop_cnt), .busy(d6_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d, input logic l);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        in_last  = l;
    endtask

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bb_data [4];
        logic [7:0] bb_vld  [4];
        bb_data = '{8'h31, 8'h32, 8'h41, 8'h42};
        bb_vld  = '{8'h08, 8'h08, 8'h10, 8'h10};

        drive(1'b0, 3'd0, 8'h00, 1'b0);
        out_ready    = 8'hFF;
        d6_in_valid  = 1'b0;
        d6_in_sel    = 3'd0;
        d6_in_data   = 8'h00;
        d6_in_last   = 1'b0;
        d6_out_ready = 6'h3F;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_drop_cnt",  drop_cnt,  0);
        chk("rst_busy",      busy,      0);
        rst = 1'b0;
        tick();

        // ---- single-beat packets on every channel, back to back ----
        for (int s = 0; s < 8; s++) begin
            drive(1'b1, 3'(s), 8'hA0 + 8'(s), 1'b1);
            #1;
            chk("sb_in_ready", in_ready, 1);
            tick();
            chk("sb_out_valid", out_valid, 32'h1 << s);
            chk("sb_out_data",  out_data,  32'hA0 + s);
            chk("sb_out_last",  out_last,  1);
            chk("sb_busy",      busy,      0);
        end
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        chk("sb_drain_valid", out_valid, 0);

        // ---- 4-beat packet on ch5, select changes after first beat ----
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, (k == 0) ? 3'd5 : 3'(k * 3), 8'h50 + 8'(k), k == 3);
            tick();
            chk("p4_out_valid", out_valid, 32'h20);
            chk("p4_out_data",  out_data,  32'h50 + k);
            chk("p4_out_last",  out_last,  (k == 3) ? 1 : 0);
            chk("p4_busy",      busy,      (k < 3) ? 1 : 0);
        end
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        chk("p4_drain_valid", out_valid, 0);

        // ---- ch2 packet with 3 cycles of sink back-pressure ----
        drive(1'b1, 3'd2, 8'hC0, 1'b0);
        tick();
        chk("bp_b0_valid", out_valid, 32'h04);
        chk("bp_b0_data",  out_data,  32'hC0);
        out_ready = 8'hFB;
        drive(1'b1, 3'd7, 8'hC1, 1'b0);
        #1;
        chk("bp_stall_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 32'h04);
            chk("bp_hold_data",  out_data,  32'hC0);
            chk("bp_hold_last",  out_last,  0);
            chk("bp_hold_ready", in_ready,  0);
        end
        out_ready = 8'hFF;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_b1_valid", out_valid, 32'h04);
        chk("bp_b1_data",  out_data,  32'hC1);
        drive(1'b1, 3'd0, 8'hC2, 1'b1);
        tick();
        chk("bp_b2_data", out_data, 32'hC2);
        chk("bp_b2_last", out_last, 1);
        chk("bp_b2_busy", busy,     0);
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        chk("bp_drain_valid", out_valid, 0);

        // ---- reset pulse mid-packet with a held beat ----
        drive(1'b1, 3'd6, 8'hD0, 1'b0);
        tick();
        chk("mr_pre_valid", out_valid, 32'h40);
        chk("mr_pre_busy",  busy,      1);
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        chk("mr_rst_ready", in_ready, 0);
        tick();
        chk("mr_post_valid", out_valid, 0);
        chk("mr_post_busy",  busy,      0);
        rst = 1'b0;
        drive(1'b1, 3'd1, 8'hE1, 1'b1);
        tick();
        chk("mr_new_valid", out_valid, 32'h02);
        chk("mr_new_data",  out_data,  32'hE1);
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        tick();

        // ---- back-to-back packets ch3 then ch4 ----
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, (k < 2) ? 3'd3 : 3'd4, bb_data[k], (k == 1) || (k == 3));
            #1;
            chk("bb_in_ready", in_ready, 1);
            tick();
            chk("bb_out_valid", out_valid, {24'h0, bb_vld[k]});
            chk("bb_out_data",  out_data,  {24'h0, bb_data[k]});
        end
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        chk("bb_drain_valid", out_valid, 0);

        // ---- 6-channel build: packets to sel=7 are discarded and counted ----
        for (int p = 0; p < 260; p++) begin
            for (int b = 0; b < 3; b++) begin
                d6_in_valid = 1'b1;
                d6_in_sel   = 3'd7;
                d6_in_data  = 8'(b);
                d6_in_last  = (b == 2);
                #1;
                if (p == 0) chk("dr_in_ready", d6_in_ready, 1);
                tick();
                if (p == 0) begin
                    chk("dr_out_valid", d6_out_valid, 0);
                    chk("dr_busy",      d6_busy,      (b < 2) ? 1 : 0);
                end
            end
            if (p == 0) chk("dr_cnt_first", d6_drop_cnt, 1);
        end
        chk("dr_cnt_sat", d6_drop_cnt, 255);
        chk("dr_main_cnt", drop_cnt, 0);

        // highest legal channel of the 6-channel build still routes
        d6_in_sel  = 3'd5;
        d6_in_data = 8'h5A;
        d6_in_last = 1'b1;
        tick();
        chk("d6_ch5_valid", d6_out_valid, 32'h20);
        chk("d6_ch5_data",  d6_out_data,  32'h5A);
        chk("d6_cnt_hold",  d6_drop_cnt,  255);
        d6_in_valid = 1'b0;
        tick();
        chk("d6_drain_valid", d6_out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
